// File: rtl/gol_pkg.sv
// gol_pkg: shared types, rule constants and cell-index helper for the
// Game of Life engine (game_of_life / gol_cell).
package gol_pkg;

    typedef logic [3:0] nbr_cnt_t;

    localparam nbr_cnt_t BIRTH_CNT   = 4'd3;
    localparam nbr_cnt_t SURVIVE_MIN = 4'd2;
    localparam nbr_cnt_t SURVIVE_MAX = 4'd3;

    // Flat bit index of cell (row, col) in a size x size field.
    function automatic int idx(input int row, input int col, input int size);
        return row * size + col;
    endfunction

endpackage

// File: rtl/gol_cell.sv
// gol_cell: combinational next-state logic for a single Game of Life cell.
// Ports:
//   alive      in  1  current state of this cell
//   nbrs       in  8  current states of the 8 Moore neighbours
//   next_alive out 1  state of this cell in the next generation
module gol_cell
    import gol_pkg::*;
(
    input  logic       alive,
    input  logic [7:0] nbrs,
    output logic       next_alive
);

    nbr_cnt_t count;

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            count = count + nbr_cnt_t'(nbrs[i]);
        end
        if (alive) begin
            next_alive = (count >= SURVIVE_MIN) && (count <= SURVIVE_MAX);
        end else begin
            next_alive = (count == BIRTH_CNT);
        end
    end

endmodule

// File: rtl/game_of_life.sv
// game_of_life: synchronous Conway's Game of Life engine over a SIZE x SIZE
// bit field; one generation per clock, seed loaded on reset.
// Configuration macro: GOL_TORUS_EN (defined -> toroidal wrap-around grid,
// undefined -> cells outside the grid count as dead).
// Ports:
//   clk       in   1          clock, all updates on posedge
//   rst       in   1          synchronous active-high; loads field_in
//   field_in  in   SIZE*SIZE  seed pattern, sampled only while rst=1
//   field     out  SIZE*SIZE  current generation (bit row*SIZE+col), registered
module game_of_life
    import gol_pkg::*;
#(
    parameter int SIZE = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIZE*SIZE-1:0]   field_in,
    output logic [SIZE*SIZE-1:0]   field
);

    logic [SIZE*SIZE-1:0] next_field;

    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            logic [7:0] nbrs;

            // k walks the 3x3 window row-major; k=4 is the cell itself.
            for (genvar k = 0; k < 9; k++) begin : g_nbr
                if (k != 4) begin : g_use
                    localparam int DR = k / 3 - 1;
                    localparam int DC = k % 3 - 1;
                    localparam int NB = (k < 4) ? k : k - 1;
`ifdef GOL_TORUS_EN
                    localparam int NR = (r + DR + SIZE) % SIZE;
                    localparam int NC = (c + DC + SIZE) % SIZE;
                    assign nbrs[NB] = field[idx(NR, NC, SIZE)];
`else
                    localparam int NR = r + DR;
                    localparam int NC = c + DC;
                    if (NR >= 0 && NR < SIZE && NC >= 0 && NC < SIZE) begin : g_in
                        assign nbrs[NB] = field[idx(NR, NC, SIZE)];
                    end else begin : g_out
                        assign nbrs[NB] = 1'b0;
                    end
`endif
                end
            end

            gol_cell u_cell (
                .alive      (field[idx(r, c, SIZE)]),
                .nbrs       (nbrs),
                .next_alive (next_field[idx(r, c, SIZE)])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            field <= field_in;
        end else begin
            field <= next_field;
        end
    end

endmodule

// File: tb/tb_game_of_life.sv
// tb_game_of_life: self-checking bench for game_of_life (SIZE=5).
// Expected generations are queued when stimulus is driven and compared
// after the corresponding clock edge.
module tb_game_of_life;

    localparam int SIZE = 5;
    localparam int N    = SIZE * SIZE;

    localparam logic [N-1:0] BLINK_V = (25'd1 << 7)  | (25'd1 << 12) | (25'd1 << 17);
    localparam logic [N-1:0] BLINK_H = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
    localparam logic [N-1:0] BLOCK   = (25'd1 << 6)  | (25'd1 << 7)  | (25'd1 << 11) | (25'd1 << 12);
    localparam logic [N-1:0] CORNERS = (25'd1 << 0)  | (25'd1 << 4)  | (25'd1 << 20) | (25'd1 << 24);
    localparam logic [N-1:0] LONE    = 25'd1 << 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] field_in;
    logic [N-1:0] field;

    logic [N-1:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    game_of_life #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .field_in (field_in),
        .field    (field)
    );

    always #5 clk = ~clk;

    // Independent reference: counts neighbours with explicit coordinates.
    function automatic logic [N-1:0] ref_next(input logic [N-1:0] f);
        logic [N-1:0] nf;
        nf = '0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
`ifdef GOL_TORUS_EN
                        rr = (rr + SIZE) % SIZE;
                        cc = (cc + SIZE) % SIZE;
`else
                        if (rr < 0 || rr >= SIZE || cc < 0 || cc >= SIZE) continue;
`endif
                        if (f[rr*SIZE+cc]) cnt++;
                    end
                end
                if (f[r*SIZE+c]) nf[r*SIZE+c] = (cnt == 2 || cnt == 3);
                else             nf[r*SIZE+c] = (cnt == 3);
            end
        end
        return nf;
    endfunction

    // Drive one cycle's inputs, queue its expected result, wait past the edge.
    task automatic drive_edge(input logic r, input logic [N-1:0] fin, input logic [N-1:0] e);
        rst      = r;
        field_in = fin;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [N-1:0] e;
        drive_edge(1'b1, BLINK_V, BLINK_V);
        e = exp_q.pop_front();
        vectors++;
        if (field !== e) begin
            miscompares++;
            $display("FAIL reset_seed: got %h expected %h", field, e);
        end
    endtask

    task automatic test_blinker();
        logic [N-1:0] e;
        drive_edge(1'b1, BLINK_V, BLINK_V);
        void'(exp_q.pop_front());
        for (int g = 1; g <= 4; g++) begin
            // field_in scrambled while rst=0 must have no effect
            drive_edge(1'b0, N'($urandom), (g % 2) ? BLINK_H : BLINK_V);
            e = exp_q.pop_front();
            vectors++;
            if (field !== e) begin
                miscompares++;
                $display("FAIL blinker_gen%0d: got %h expected %h", g, field, e);
            end
        end
    endtask

    task automatic test_block();
        logic [N-1:0] e;
        drive_edge(1'b1, BLOCK, BLOCK);
        void'(exp_q.pop_front());
        for (int g = 1; g <= 5; g++) begin
            drive_edge(1'b0, '0, BLOCK);
            e = exp_q.pop_front();
            vectors++;
            if (field !== e) begin
                miscompares++;
                $display("FAIL block_gen%0d: got %h expected %h", g, field, e);
            end
        end
    endtask

    task automatic test_full_field();
        logic [N-1:0] e;
        drive_edge(1'b1, '1, '1);
        e = exp_q.pop_front();
        vectors++;
        if (field !== e) begin
            miscompares++;
            $display("FAIL full_seed: got %h expected %h", field, e);
        end
`ifdef GOL_TORUS_EN
        drive_edge(1'b0, '0, '0);
`else
        drive_edge(1'b0, '0, CORNERS);
`endif
        e = exp_q.pop_front();
        vectors++;
        if (field !== e) begin
            miscompares++;
            $display("FAIL full_gen1: got %h expected %h", field, e);
        end
        for (int g = 2; g <= 3; g++) begin
            drive_edge(1'b0, '0, '0);
            e = exp_q.pop_front();
            vectors++;
            if (field !== e) begin
                miscompares++;
                $display("FAIL full_gen%0d: got %h expected %h", g, field, e);
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic [N-1:0] e;
        drive_edge(1'b1, BLINK_V, BLINK_V);
        void'(exp_q.pop_front());
        for (int g = 1; g <= 3; g++) begin
            drive_edge(1'b0, BLOCK, (g % 2) ? BLINK_H : BLINK_V);
            void'(exp_q.pop_front());
        end
        drive_edge(1'b1, BLOCK, BLOCK);
        e = exp_q.pop_front();
        vectors++;
        if (field !== e) begin
            miscompares++;
            $display("FAIL midrun_reload: got %h expected %h", field, e);
        end
        for (int g = 1; g <= 2; g++) begin
            drive_edge(1'b0, '0, BLOCK);
            e = exp_q.pop_front();
            vectors++;
            if (field !== e) begin
                miscompares++;
                $display("FAIL midrun_stable%0d: got %h expected %h", g, field, e);
            end
        end
    endtask

    task automatic test_empty_lone();
        logic [N-1:0] e;
        drive_edge(1'b1, '0, '0);
        void'(exp_q.pop_front());
        for (int g = 1; g <= 3; g++) begin
            drive_edge(1'b0, '1, '0);
            e = exp_q.pop_front();
            vectors++;
            if (field !== e) begin
                miscompares++;
                $display("FAIL empty_gen%0d: got %h expected %h", g, field, e);
            end
        end
        drive_edge(1'b1, LONE, LONE);
        e = exp_q.pop_front();
        vectors++;
        if (field !== e) begin
            miscompares++;
            $display("FAIL lone_seed: got %h expected %h", field, e);
        end
        drive_edge(1'b0, '0, '0);
        e = exp_q.pop_front();
        vectors++;
        if (field !== e) begin
            miscompares++;
            $display("FAIL lone_gen1: got %h expected %h", field, e);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] seed;
        logic [N-1:0] model;
        logic [N-1:0] e;
        for (int s = 0; s < 8; s++) begin
            seed  = N'($urandom);
            model = seed;
            drive_edge(1'b1, seed, model);
            e = exp_q.pop_front();
            vectors++;
            if (field !== e) begin
                miscompares++;
                $display("FAIL rand%0d_seed: got %h expected %h", s, field, e);
            end
            for (int g = 1; g <= 4; g++) begin
                model = ref_next(model);
                drive_edge(1'b0, N'($urandom), model);
                e = exp_q.pop_front();
                vectors++;
                if (field !== e) begin
                    miscompares++;
                    $display("FAIL rand%0d_gen%0d: got %h expected %h", s, g, field, e);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        field_in = '0;
        test_reset();
        test_blinker();
        test_block();
        test_full_field();
        test_midrun_reset();
        test_empty_lone();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
